// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the pipeline hazard/forwarding controller:
//   forwarding-mux select encodings, the default register-address width
//   and the width of the mult/div busy counter.
package hazard_pkg;

  // Default register-address width (32 architectural registers).
  localparam int RA_W_DEF = 5;

  // Width of the mult/div busy counter; bounds MD_LATENCY to 1..15.
  localparam int MD_CNT_W = 4;

  // Select values for the E-stage operand forwarding muxes.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,  // register file value
    FWD_WB   = 2'b01,  // result from W stage
    FWD_MEM  = 2'b10   // ALU result from M stage
  } fwd_sel_e;

endpackage

// File: rtl/md_busy_tracker.sv
// md_busy_tracker
//   Tracks how long the multi-cycle mult/div unit remains busy after an
//   operation issues from E.
//
//   Ports:
//     clk         in   clock
//     rst_n       in   asynchronous active-low reset
//     md_start_i  in   mult/div issuing from E this cycle
//     stall_i     in   E stage held (issue is not taken while held)
//     md_busy_o   out  mult/div result not yet available
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  input  logic stall_i,
  output logic md_busy_o
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] cnt_q;
  logic [MD_CNT_W-1:0] cnt_d;

  // A new issue reloads the counter even when the previous operation is
  // in its last busy cycle. The countdown itself ignores stalls: the
  // functional unit keeps working while memory holds the pipeline.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start_i && !stall_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for the 5-stage F/D/E/M/W pipeline.
//   Produces forwarding-mux selects, pipeline-register stall/flush
//   controls, the mult/div busy flag and a saturating stall-cycle counter.
//
//   Ports:
//     clk, rst_n                         clock, async active-low reset
//     rsD, rtD, rsE, rtE                 source registers in D and E
//     WriteRegE/M/W, RegWriteE/M/W       destination register and valid
//     MemToRegE, MemToRegM               load in E / M
//     BranchD, JumpRegD, MdD             branch / jr / mult-div op in D
//     MdStartE                           mult/div issuing from E
//     DMemReqM, DMemReadyM               data-memory request / completion
//     ForwardaD, ForwardbD               M->D forward for comparator/jr
//     ForwardaE, ForwardbE               E operand forwarding selects
//     StallF, StallD, StallE, StallM     hold pipeline registers
//     FlushE, FlushW                     insert bubble into E / W
//     MdBusy                             mult/div in progress
//     StallCnt                           saturating count of StallD cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W       = RA_W_DEF,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  rsD,
  input  logic [RA_W-1:0]  rtD,
  input  logic [RA_W-1:0]  rsE,
  input  logic [RA_W-1:0]  rtE,
  input  logic [RA_W-1:0]  WriteRegE,
  input  logic [RA_W-1:0]  WriteRegM,
  input  logic [RA_W-1:0]  WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             JumpRegD,
  input  logic             MdD,
  input  logic             MdStartE,
  input  logic             DMemReqM,
  input  logic             DMemReadyM,
  output logic             ForwardaD,
  output logic             ForwardbD,
  output logic [1:0]       ForwardaE,
  output logic [1:0]       ForwardbE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCnt
);

  // True when a is a real register (not $0) and equals b. $0 is hardwired
  // to zero, so a match on it is never a dependency.
  function automatic logic nz_eq(input logic [RA_W-1:0] a,
                                 input logic [RA_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Selects the newest in-flight value for an E-stage source register;
  // M holds the younger result so it wins over W.
  function automatic fwd_sel_e fwd_sel(input logic [RA_W-1:0] src);
    if (RegWriteM && nz_eq(src, WriteRegM)) begin
      return FWD_MEM;
    end else if (RegWriteW && nz_eq(src, WriteRegW)) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

  logic lwstall;
  logic brstall;
  logic jrstall;
  logic mdstall;
  logic memstall;
  logic any_d_stall;
  logic md_busy;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // ---------------------------------------------------------------- forwarding
  assign ForwardaD = RegWriteM && nz_eq(rsD, WriteRegM);
  assign ForwardbD = RegWriteM && nz_eq(rtD, WriteRegM);

  always_comb begin
    ForwardaE = fwd_sel(rsE);
    ForwardbE = fwd_sel(rtE);
  end

  // ---------------------------------------------------------------- stalls
  // Load result is not available to D until it leaves M.
  assign lwstall = MemToRegE && (nz_eq(rtE, rsD) || nz_eq(rtE, rtD));

  // Branch comparison happens in D, so an ALU result still in E, or a load
  // still in M, cannot be forwarded in time.
  assign brstall = BranchD &&
                   ((RegWriteE && (nz_eq(WriteRegE, rsD) || nz_eq(WriteRegE, rtD))) ||
                    (MemToRegM && (nz_eq(WriteRegM, rsD) || nz_eq(WriteRegM, rtD))));

  // jr/jalr reads only rs, with the same timing as a branch.
  assign jrstall = JumpRegD &&
                   ((RegWriteE && nz_eq(WriteRegE, rsD)) ||
                    (MemToRegM && nz_eq(WriteRegM, rsD)));

  // An op issuing from E this cycle counts as busy even before the
  // tracker has loaded.
  assign mdstall  = MdD && (md_busy || MdStartE);

  assign memstall = DMemReqM && !DMemReadyM;

  assign any_d_stall = lwstall || brstall || jrstall || mdstall;

  assign StallF = any_d_stall || memstall;
  assign StallD = any_d_stall || memstall;
  assign StallE = memstall;
  assign StallM = memstall;

  // While memory holds E, E must keep its instruction rather than take a
  // bubble; the D-stage hazard is resolved once memory completes.
  assign FlushE = any_d_stall && !memstall;
  assign FlushW = memstall;

  // ---------------------------------------------------------------- mult/div
  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (MdStartE),
    .stall_i    (StallE),
    .md_busy_o  (md_busy)
  );

  assign MdBusy = md_busy;

  // ---------------------------------------------------------------- stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RA_W = 5;
  localparam int LAT0 = 4;
  localparam int CW0  = 3;
  localparam int LAT1 = 1;
  localparam int CW1  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [RA_W-1:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic            RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic            BranchD, JumpRegD, MdD, MdStartE, DMemReqM, DMemReadyM;

  logic            ForwardaD, ForwardbD, StallF, StallD, StallE, StallM;
  logic            FlushE, FlushW, MdBusy;
  logic [1:0]      ForwardaE, ForwardbE;
  logic [CW0-1:0]  StallCnt;

  logic            ForwardaD1, ForwardbD1, StallF1, StallD1, StallE1, StallM1;
  logic            FlushE1, FlushW1, MdBusy1;
  logic [1:0]      ForwardaE1, ForwardbE1;
  logic [CW1-1:0]  StallCnt1;

  hazard_ctrl #(.RA_W(RA_W), .MD_LATENCY(LAT0), .CNT_W(CW0)) dut (
    .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD),
    .JumpRegD(JumpRegD), .MdD(MdD), .MdStartE(MdStartE), .DMemReqM(DMemReqM),
    .DMemReadyM(DMemReadyM), .ForwardaD(ForwardaD), .ForwardbD(ForwardbD),
    .ForwardaE(ForwardaE), .ForwardbE(ForwardbE), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushE(FlushE),
    .FlushW(FlushW), .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  hazard_ctrl #(.RA_W(RA_W), .MD_LATENCY(LAT1), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD),
    .JumpRegD(JumpRegD), .MdD(MdD), .MdStartE(MdStartE), .DMemReqM(DMemReqM),
    .DMemReadyM(DMemReadyM), .ForwardaD(ForwardaD1), .ForwardbD(ForwardbD1),
    .ForwardaE(ForwardaE1), .ForwardbE(ForwardbE1), .StallF(StallF1),
    .StallD(StallD1), .StallE(StallE1), .StallM(StallM1), .FlushE(FlushE1),
    .FlushW(FlushW1), .MdBusy(MdBusy1), .StallCnt(StallCnt1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (time-based, not counter-based)
  int  cyc;             // index of the current clock period
  int  last_iss;        // period in which the latest mult/div issue was accepted
  int  nstall0, nstall1;
  bit  exp_sd0, exp_sd1, exp_mem;

  function automatic bit dep(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  // Busy for the LAT periods following the issue period.
  function automatic bit busy_at(input int lat);
    int age;
    age = cyc - last_iss;
    return (age >= 1) && (age <= lat);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [RA_W-1:0] src);
    if (RegWriteM && dep(src, WriteRegM)) return 2'b10;
    if (RegWriteW && dep(src, WriteRegW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemToRegE = 0; MemToRegM = 0; BranchD = 0; JumpRegD = 0;
    MdD = 0; MdStartE = 0; DMemReqM = 0; DMemReadyM = 1;
  endtask

  // Sample point of the current period: checks every output of both DUTs.
  task automatic cycle_a();
    bit ld, br, jr, md0, md1, hz0, hz1;
    #3;
    ld = MemToRegE && (dep(rtE, rsD) || dep(rtE, rtD));
    br = BranchD && ((RegWriteE && (dep(WriteRegE, rsD) || dep(WriteRegE, rtD))) ||
                     (MemToRegM && (dep(WriteRegM, rsD) || dep(WriteRegM, rtD))));
    jr = JumpRegD && ((RegWriteE && dep(WriteRegE, rsD)) ||
                      (MemToRegM && dep(WriteRegM, rsD)));
    md0 = MdD && (busy_at(LAT0) || MdStartE);
    md1 = MdD && (busy_at(LAT1) || MdStartE);
    exp_mem = DMemReqM && !DMemReadyM;
    hz0 = ld || br || jr || md0;
    hz1 = ld || br || jr || md1;
    exp_sd0 = hz0 || exp_mem;
    exp_sd1 = hz1 || exp_mem;

    chk("fwdaD",  ForwardaD, RegWriteM && dep(rsD, WriteRegM));
    chk("fwdbD",  ForwardbD, RegWriteM && dep(rtD, WriteRegM));
    chk("fwdaE",  ForwardaE, fwd_e(rsE));
    chk("fwdbE",  ForwardbE, fwd_e(rtE));
    chk("stallF", StallF, exp_sd0);
    chk("stallD", StallD, exp_sd0);
    chk("stallE", StallE, exp_mem);
    chk("stallM", StallM, exp_mem);
    chk("flushE", FlushE, hz0 && !exp_mem);
    chk("flushW", FlushW, exp_mem);
    chk("mdbusy", MdBusy, busy_at(LAT0));
    chk("stcnt",  StallCnt, sat(nstall0, CW0));
    chk("stallD_l1", StallD1, exp_sd1);
    chk("flushE_l1", FlushE1, hz1 && !exp_mem);
    chk("mdbusy_l1", MdBusy1, busy_at(LAT1));
    chk("stcnt_l1",  StallCnt1, sat(nstall1, CW1));
    $display("cyc=%0d sd=%b se=%b fe=%b fw=%b busy=%b cnt=%0d | sd1=%b busy1=%b cnt1=%0d",
             cyc, StallD, StallE, FlushE, FlushW, MdBusy, StallCnt, StallD1, MdBusy1, StallCnt1);
  endtask

  // Advance the model across the clock edge, then move to the drive point.
  task automatic cycle_b();
    if (rst_n) begin
      if (MdStartE && !exp_mem) last_iss = cyc;
      if (exp_sd0) nstall0++;
      if (exp_sd1) nstall1++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    last_iss = -1000;
    nstall0 = 0;
    nstall1 = 0;
  endtask

  // Assert reset in the middle of a period; registers must clear at once.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mdbusy",  MdBusy, 1'b0);
    chk("rst_stcnt",   StallCnt, 0);
    chk("rst_mdbusy1", MdBusy1, 1'b0);
    chk("rst_stcnt1",  StallCnt1, 0);
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  function automatic logic [RA_W-1:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? RA_W'(31) : RA_W'(r);
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("init_mdbusy", MdBusy, 1'b0);
    chk("init_stcnt", StallCnt, 0);
    rst_n = 1'b1;

    // Forwarding priority: M, then W, then $0 never forwarded.
    rsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
    cycle_a(); chk("dir_fwd_mem", ForwardaE, 2'b10); cycle_b();
    RegWriteM = 0;
    cycle_a(); chk("dir_fwd_wb", ForwardaE, 2'b01); cycle_b();
    rsE = 0;
    cycle_a(); chk("dir_fwd_none", ForwardaE, 2'b00); cycle_b();

    // Load-use stall then release.
    clear_inputs(); MemToRegE = 1; rtE = 5; rsD = 5;
    cycle_a(); chk("dir_lw_sd", StallD, 1'b1); chk("dir_lw_fe", FlushE, 1'b1);
    chk("dir_lw_se", StallE, 1'b0); cycle_b();
    MemToRegE = 0;
    cycle_a(); chk("dir_lw_clr", StallD, 1'b0); cycle_b();

    // Mult/div issue with MdD held: stall through the busy window.
    clear_inputs(); MdStartE = 1; MdD = 1;
    cycle_a(); chk("dir_md_t", StallD, 1'b1); cycle_b();
    MdStartE = 0;
    for (int i = 1; i <= 4; i++) begin
      cycle_a(); chk("dir_md_busy", MdBusy, 1'b1); chk("dir_md_sd", StallD, 1'b1); cycle_b();
    end
    cycle_a(); chk("dir_md_done", MdBusy, 1'b0); chk("dir_md_sd_done", StallD, 1'b0); cycle_b();

    // Memory wait states on top of a load-use hazard.
    clear_inputs(); MemToRegE = 1; rtE = 5; rsD = 5; DMemReqM = 1; DMemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      cycle_a(); chk("dir_mem_se", StallE, 1'b1); chk("dir_mem_fw", FlushW, 1'b1);
      chk("dir_mem_fe", FlushE, 1'b0); cycle_b();
    end
    DMemReadyM = 1;
    cycle_a(); chk("dir_mem_rdy_se", StallE, 1'b0); chk("dir_mem_rdy_fe", FlushE, 1'b1); cycle_b();

    // jr hazard, and $0 never stalls.
    clear_inputs(); JumpRegD = 1; rsD = 31; RegWriteE = 1; WriteRegE = 31;
    cycle_a(); chk("dir_jr_sd", StallD, 1'b1); cycle_b();
    rsD = 0; WriteRegE = 0;
    cycle_a(); chk("dir_jr_r0", StallD, 1'b0); cycle_b();

    // Latency-1 instance: busy for exactly one period.
    clear_inputs(); MdStartE = 1;
    cycle_a(); cycle_b();
    MdStartE = 0;
    cycle_a(); chk("dir_l1_busy", MdBusy1, 1'b1); cycle_b();
    cycle_a(); chk("dir_l1_idle", MdBusy1, 1'b0); cycle_b();

    // Async reset in the middle of a mult/div operation.
    clear_inputs(); MdStartE = 1;
    cycle_a(); cycle_b();
    MdStartE = 0;
    cycle_a(); cycle_b();
    cycle_a(); chk("dir_pre_rst_busy", MdBusy, 1'b1);
    async_reset();

    // 10 continuous stall periods saturate the 3-bit counter at 7.
    clear_inputs(); MemToRegE = 1; rtE = 5; rsD = 5;
    for (int i = 0; i < 10; i++) begin
      cycle_a(); cycle_b();
    end
    clear_inputs();
    cycle_a(); chk("dir_sat", StallCnt, 7); chk("dir_cnt16", StallCnt1, 10); cycle_b();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rsD = rnd_reg(); rtD = rnd_reg(); rsE = rnd_reg(); rtE = rnd_reg();
      WriteRegE = rnd_reg(); WriteRegM = rnd_reg(); WriteRegW = rnd_reg();
      RegWriteE = ($urandom_range(0, 1) == 1);
      RegWriteM = ($urandom_range(0, 1) == 1);
      RegWriteW = ($urandom_range(0, 1) == 1);
      MemToRegE = ($urandom_range(0, 3) == 0);
      MemToRegM = ($urandom_range(0, 3) == 0);
      BranchD   = ($urandom_range(0, 3) == 0);
      JumpRegD  = ($urandom_range(0, 5) == 0);
      MdD       = ($urandom_range(0, 3) == 0);
      MdStartE  = ($urandom_range(0, 6) == 0);
      DMemReqM  = ($urandom_range(0, 2) == 0);
      DMemReadyM = ($urandom_range(0, 9) < 6);
      cycle_a();
      if (i == 150) begin
        async_reset();
      end else begin
        cycle_b();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
